// File: rtl/router_pkg.sv
// Shared constants and FSM state encoding for the 1x3 router datapath and control.
package router_pkg;

    localparam int         ROUTER_DW    = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

    function automatic logic addr_is_valid(input logic [1:0] addr);
        return addr != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity of a packet, captured parity byte, and the error flag
// comparing the two once the packet's parity byte has arrived.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DW = ROUTER_DW
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clr,
    input  logic          acc_en,
    input  logic [DW-1:0] acc_data,
    input  logic          cap_en,
    input  logic [DW-1:0] cap_data,
    input  logic          cmp_en,
    output logic          err
);

    logic [DW-1:0] int_par_q, int_par_d;
    logic [DW-1:0] pkt_par_q, pkt_par_d;
    logic          err_q, err_d;

    always_comb begin
        int_par_d = int_par_q;
        pkt_par_d = pkt_par_q;
        err_d     = err_q;

        if (clr) begin
            int_par_d = '0;
        end else if (acc_en) begin
            int_par_d = int_par_q ^ acc_data;
        end

        if (cap_en) begin
            pkt_par_d = cap_data;
        end

        // Clear has priority; the compare keeps refreshing while enabled.
        if (clr) begin
            err_d = 1'b0;
        end else if (cmp_en) begin
            err_d = (int_par_q != pkt_par_q);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_par_q <= '0;
            pkt_par_q <= '0;
            err_q     <= 1'b0;
        end else begin
            int_par_q <= int_par_d;
            pkt_par_q <= pkt_par_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, single-entry hold for FIFO-full
// stalls, registered FIFO write bus and parity status returned to the FSM.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = ROUTER_DW
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] header_q, header_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  parity_done_q, parity_done_d;
    logic                  low_pkt_valid_q, low_pkt_valid_d;

    logic                  lfd_go, ld_go, laf_go;
    logic                  acc_en, cap_en, cmp_en;
    logic [DATA_WIDTH-1:0] acc_data;

    // Strobes are exclusive from the FSM; the masking only fixes a priority order.
    assign lfd_go = lfd_state & ~detect_add;
    assign ld_go  = ld_state  & ~detect_add & ~lfd_state;
    assign laf_go = laf_state & ~detect_add & ~lfd_state & ~ld_state;

    always_comb begin
        header_d        = header_q;
        hold_d          = hold_q;
        dout_d          = dout_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;

        if (detect_add && pkt_valid && addr_is_valid(data_in[1:0])) begin
            header_d = data_in;
        end

        if (lfd_go) begin
            dout_d = header_q;
        end else if (ld_go && !fifo_full) begin
            dout_d = data_in;
        end else if (ld_go && fifo_full) begin
            hold_d = data_in;
        end else if (laf_go) begin
            dout_d = hold_q;
        end

        if (rst_int_reg || detect_add) begin
            low_pkt_valid_d = 1'b0;
        end else if (ld_go && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end

        // Parity byte either goes straight out, or leaves the hold after a stall.
        if (detect_add) begin
            parity_done_d = 1'b0;
        end else if ((ld_go && !fifo_full && !pkt_valid) ||
                     (laf_go && low_pkt_valid_q && !parity_done_q)) begin
            parity_done_d = 1'b1;
        end
    end

    assign acc_en   = lfd_go | (ld_go & pkt_valid & ~full_state);
    assign acc_data = lfd_go ? header_q : data_in;
    assign cap_en   = ld_go & ~pkt_valid;
    assign cmp_en   = parity_done_q & ~detect_add;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_q        <= '0;
            hold_q          <= '0;
            dout_q          <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            header_q        <= header_d;
            hold_q          <= hold_d;
            dout_q          <= dout_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    router_parity_chk #(
        .DW(DATA_WIDTH)
    ) u_parity_chk (
        .clock    (clock),
        .resetn   (resetn),
        .clr      (detect_add),
        .acc_en   (acc_en),
        .acc_data (acc_data),
        .cap_en   (cap_en),
        .cap_data (data_in),
        .cmp_en   (cmp_en),
        .err      (err)
    );

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg.sv
// Bench for router_reg: directed vector table, asynchronous reset check and
// random packets scored against a byte-stream / XOR-parity model.
module tb_router_reg;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];

    // Strobe word order: {detect_add, lfd, ld, laf, full_state, rst_int_reg}
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_DA   = 6'b100000;
    localparam logic [5:0] S_LFD  = 6'b010000;
    localparam logic [5:0] S_LD   = 6'b001000;
    localparam logic [5:0] S_LAF  = 6'b000100;
    localparam logic [5:0] S_FS   = 6'b000010;
    localparam logic [5:0] S_RIR  = 6'b000001;

    localparam logic [7:0] GP = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
    localparam logic [7:0] FP = 8'h0D ^ 8'h11 ^ 8'h44 ^ 8'h55;
    localparam logic [7:0] QP = 8'h0D ^ 8'h11 ^ 8'h22;

    typedef struct {
        logic [5:0] strb;
        logic       pv;
        logic [7:0] din;
        logic       ff;
        logic [7:0] e_dout;
        logic       e_pd;
        logic       e_lpv;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    router_reg #(.DATA_WIDTH(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(input logic [5:0] s, input logic pv, input logic [7:0] d,
                                 input logic ff, input logic [7:0] e_dout, input logic e_pd,
                                 input logic e_lpv, input logic e_err);
        vec_t v;
        v.strb = s; v.pv = pv; v.din = d; v.ff = ff;
        v.e_dout = e_dout; v.e_pd = e_pd; v.e_lpv = e_lpv; v.e_err = e_err;
        return v;
    endfunction

    // Driver: present one cycle of inputs, then sample 1 time unit after the edge
    task automatic cyc(input logic [5:0] s, input logic pv, input logic [7:0] d, input logic ff);
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = s;
        pkt_valid = pv;
        data_in   = d;
        fifo_full = ff;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Scoreboard: every FIFO write must match the next byte of the modelled stream
    task automatic chk_write(input string name);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: write seen with empty expected queue, dout=%02h", name, dout);
        end else begin
            chk(name, dout, exp_q.pop_front());
        end
    endtask

    task automatic rand_packet(input int k);
        logic [7:0] hdr, par, calc, b;
        logic [7:0] pl[$];
        logic       exp_err;
        int         len, stall;
        hdr = 8'($urandom_range(0, 255));
        hdr[1:0] = 2'($urandom_range(0, 2));
        len = $urandom_range(1, 6);
        calc = hdr;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            pl.push_back(b);
            calc = calc ^ b;
        end
        par = ($urandom_range(0, 1) == 1) ? calc : (calc ^ 8'($urandom_range(1, 255)));
        exp_err = (par != calc);
        stall = $urandom_range(0, len + 3);
        exp_q.push_back(hdr);
        foreach (pl[i]) exp_q.push_back(pl[i]);
        exp_q.push_back(par);

        cyc(S_DA, 1'b1, hdr, 1'b0);
        cyc(S_LFD, 1'b1, pl[0], 1'b0);
        chk_write($sformatf("pkt%0d hdr", k));
        for (int i = 0; i < len; i++) begin
            if (i == stall) begin
                cyc(S_LD, 1'b1, pl[i], 1'b1);
                cyc(S_FS, 1'b1, pl[i], 1'b1);
                cyc(S_LAF, 1'b1, pl[i], 1'b0);
            end else begin
                cyc(S_LD, 1'b1, pl[i], 1'b0);
            end
            chk_write($sformatf("pkt%0d byte%0d", k, i));
        end
        if (stall == len) begin
            cyc(S_LD, 1'b0, par, 1'b1);
            cyc(S_FS, 1'b0, par, 1'b1);
            cyc(S_LAF, 1'b0, par, 1'b0);
        end else begin
            cyc(S_LD, 1'b0, par, 1'b0);
        end
        chk_write($sformatf("pkt%0d parity", k));
        chk($sformatf("pkt%0d parity_done", k), {7'd0, parity_done}, 8'd1);
        cyc(S_RIR, 1'b0, 8'h00, 1'b0);
        chk($sformatf("pkt%0d err", k), {7'd0, err}, {7'd0, exp_err});
        chk($sformatf("pkt%0d low_pkt_valid", k), {7'd0, low_pkt_valid}, 8'd0);
    endtask

    initial begin
        resetn = 1'b0;
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_NONE;
        pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0;

        // Good packet
        vecs.push_back(mkv(S_DA,  1, 8'h0D, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(S_LFD, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  1, 8'h11, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  1, 8'h22, 0, 8'h22, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  1, 8'h33, 0, 8'h33, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  0, GP,    0, GP,    1, 1, 0));
        vecs.push_back(mkv(S_RIR, 0, 8'h00, 0, GP,    1, 0, 0));
        // Bad parity
        vecs.push_back(mkv(S_DA,  1, 8'h0D, 0, GP,    0, 0, 0));
        vecs.push_back(mkv(S_LFD, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  1, 8'h11, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  1, 8'h22, 0, 8'h22, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  1, 8'h33, 0, 8'h33, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  0, 8'h00, 0, 8'h00, 1, 1, 0));
        vecs.push_back(mkv(S_RIR, 0, 8'h00, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mkv(S_NONE,0, 8'h00, 0, 8'h00, 1, 0, 1));
        // Full stall on a payload byte
        vecs.push_back(mkv(S_DA,  1, 8'h0D, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(S_LFD, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  1, 8'h11, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  1, 8'h44, 1, 8'h11, 0, 0, 0));
        vecs.push_back(mkv(S_FS,  1, 8'h55, 1, 8'h11, 0, 0, 0));
        vecs.push_back(mkv(S_LAF, 1, 8'h55, 0, 8'h44, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  1, 8'h55, 0, 8'h55, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  0, FP,    0, FP,    1, 1, 0));
        vecs.push_back(mkv(S_RIR, 0, 8'h00, 0, FP,    1, 0, 0));
        // Parity byte arrives while full
        vecs.push_back(mkv(S_DA,  1, 8'h0D, 0, FP,    0, 0, 0));
        vecs.push_back(mkv(S_LFD, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  1, 8'h11, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  1, 8'h22, 0, 8'h22, 0, 0, 0));
        vecs.push_back(mkv(S_LD,  0, QP,    1, 8'h22, 0, 1, 0));
        vecs.push_back(mkv(S_FS,  0, QP,    1, 8'h22, 0, 1, 0));
        vecs.push_back(mkv(S_LAF, 0, 8'h00, 0, QP,    1, 1, 0));
        vecs.push_back(mkv(S_RIR, 0, 8'h00, 0, QP,    1, 0, 0));
        // Invalid address keeps the old header; then clear beats set on low_pkt_valid
        vecs.push_back(mkv(S_DA,  1, 8'h07, 0, QP,    0, 0, 0));
        vecs.push_back(mkv(S_LFD, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        vecs.push_back(mkv(S_LD | S_RIR, 0, 8'h3E, 0, 8'h3E, 1, 0, 0));
        vecs.push_back(mkv(S_NONE,0, 8'h00, 0, 8'h3E, 1, 0, 1));

        #3;
        chk("reset dout", dout, 8'h00);
        chk("reset parity_done", {7'd0, parity_done}, 8'd0);
        chk("reset low_pkt_valid", {7'd0, low_pkt_valid}, 8'd0);
        chk("reset err", {7'd0, err}, 8'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].strb, vecs[i].pv, vecs[i].din, vecs[i].ff);
            chk($sformatf("vec%0d dout", i), dout, vecs[i].e_dout);
            chk($sformatf("vec%0d parity_done", i), {7'd0, parity_done}, {7'd0, vecs[i].e_pd});
            chk($sformatf("vec%0d low_pkt_valid", i), {7'd0, low_pkt_valid}, {7'd0, vecs[i].e_lpv});
            chk($sformatf("vec%0d err", i), {7'd0, err}, {7'd0, vecs[i].e_err});
        end

        // Asynchronous reset mid-packet, between clock edges
        cyc(S_DA, 1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h11, 1'b0);
        cyc(S_LD, 1'b0, 8'hA5, 1'b0);
        chk("pre-reset dout", dout, 8'hA5);
        chk("pre-reset parity_done", {7'd0, parity_done}, 8'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async reset dout", dout, 8'h00);
        chk("async reset parity_done", {7'd0, parity_done}, 8'd0);
        chk("async reset low_pkt_valid", {7'd0, low_pkt_valid}, 8'd0);
        chk("async reset err", {7'd0, err}, 8'd0);
        #2;
        resetn = 1'b1;
        cyc(S_LFD, 1'b1, 8'h11, 1'b0);
        chk("post-reset header", dout, 8'h00);
        cyc(S_NONE, 1'b0, 8'h00, 1'b0);
        chk("post-reset err", {7'd0, err}, 8'd0);

        for (int k = 0; k < 40; k++) begin
            rand_packet(k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
